// File: rtl/fifo_matrix_loader.sv
// fifo_matrix_loader: reads ROWS matrix rows plus one vector word from a word-addressed
// memory and unpacks each word, one element per cycle, into the per-row A FIFOs and the B FIFO.
// Optional feature: define LOADER_PREFETCH_EN to add a one-word holding buffer. The read for the
// next word is then issued while the current word unpacks, so words stream back-to-back.
module fifo_matrix_loader #(
    parameter int unsigned            DATA_WIDTH = 8,
    parameter int unsigned            ROWS       = 8,
    parameter int unsigned            COLS       = 8,
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_WIDTH-1:0]      mem_address,
    output logic                       mem_read,
    input  logic                       mem_waitrequest,
    input  logic [DATA_WIDTH*COLS-1:0] mem_readdata,
    input  logic                       mem_readdatavalid,
    output logic [ROWS-1:0]            a_wr_en,
    output logic                       b_wr_en,
    output logic [DATA_WIDTH-1:0]      fifo_wr_data,
    input  logic [ROWS-1:0]            a_full,
    input  logic                       b_full
);

    localparam int unsigned WordW = $clog2(ROWS + 2);
    localparam int unsigned ElemW = $clog2(COLS + 1);
    localparam int unsigned RowW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned LineW = DATA_WIDTH * COLS;

    // Word index ROWS is the B vector; it is also the last word of a load.
    localparam logic [WordW-1:0] LastWord = WordW'(ROWS);
    localparam logic [ElemW-1:0] LastElem = ElemW'(COLS - 1);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StUnpack, StDone} state_e;

    state_e                  state_q, state_d;
    logic [WordW-1:0]        word_q, word_d;
    logic [ElemW-1:0]        elem_q, elem_d;
    logic [LineW-1:0]        line_q, line_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    mem_read_q, mem_read_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;

`ifdef LOADER_PREFETCH_EN
    logic [LineW-1:0]        hold_q, hold_d;
    logic                    hold_vld_q, hold_vld_d;
    logic                    pend_q, pend_d;
`endif

    logic                    is_a;
    logic [RowW-1:0]         row_idx;
    logic                    tgt_full;
    logic                    wr;

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [WordW-1:0] w);
        return BASE_ADDR + ADDR_WIDTH'(w);
    endfunction

    // Decode the target FIFO of the current word and gate the write on its full flag.
    always_comb begin
        is_a     = (word_q < LastWord);
        row_idx  = word_q[RowW-1:0];
        tgt_full = is_a ? a_full[row_idx] : b_full;
        wr       = (state_q == StUnpack) && !tgt_full;
        a_wr_en  = '0;
        b_wr_en  = 1'b0;
        if (wr) begin
            if (is_a) begin
                a_wr_en[row_idx] = 1'b1;
            end else begin
                b_wr_en = 1'b1;
            end
        end
    end

    // Next-state logic for the load sequencer.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        elem_d     = elem_q;
        line_d     = line_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mem_read_d = mem_read_q;
        mem_addr_d = mem_addr_q;
`ifdef LOADER_PREFETCH_EN
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        pend_d     = pend_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StReq;
                    busy_d     = 1'b1;
                    mem_read_d = 1'b1;
                    word_d     = '0;
                    mem_addr_d = BASE_ADDR;
                end
            end
            StReq: begin
                if (!mem_waitrequest) begin
                    mem_read_d = 1'b0;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (mem_readdatavalid) begin
                    line_d  = mem_readdata;
                    elem_d  = '0;
                    state_d = StUnpack;
`ifdef LOADER_PREFETCH_EN
                    if (word_q != LastWord) begin
                        mem_read_d = 1'b1;
                        mem_addr_d = word_addr(word_q + WordW'(1));
                    end
`endif
                end
            end
            StUnpack: begin
`ifdef LOADER_PREFETCH_EN
                // Background prefetch of the next word into the holding buffer.
                if (mem_read_q && !mem_waitrequest) begin
                    mem_read_d = 1'b0;
                    pend_d     = 1'b1;
                end
                if (pend_q && mem_readdatavalid) begin
                    hold_d     = mem_readdata;
                    hold_vld_d = 1'b1;
                    pend_d     = 1'b0;
                end
`endif
                if (wr) begin
                    line_d = line_q >> DATA_WIDTH;
                    elem_d = elem_q + ElemW'(1);
                    if (elem_q == LastElem) begin
                        if (word_q == LastWord) begin
                            state_d = StDone;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            word_d = word_q + WordW'(1);
`ifdef LOADER_PREFETCH_EN
                            if (hold_vld_q || (pend_q && mem_readdatavalid)) begin
                                line_d     = hold_vld_q ? hold_q : mem_readdata;
                                hold_vld_d = 1'b0;
                                pend_d     = 1'b0;
                                elem_d     = '0;
                                if (word_d != LastWord) begin
                                    mem_read_d = 1'b1;
                                    mem_addr_d = word_addr(word_q + WordW'(2));
                                end
                            end else if (mem_read_q && mem_waitrequest) begin
                                state_d = StReq;
                            end else begin
                                // Read accepted but data not back yet; WAIT captures it.
                                state_d = StWait;
                                pend_d  = 1'b0;
                            end
`else
                            mem_read_d = 1'b1;
                            mem_addr_d = word_addr(word_q + WordW'(1));
                            state_d    = StReq;
`endif
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; reset aborts any load in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            word_q     <= '0;
            elem_q     <= '0;
            line_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_read_q <= 1'b0;
            mem_addr_q <= BASE_ADDR;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            elem_q     <= elem_d;
            line_q     <= line_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_read_q <= mem_read_d;
            mem_addr_q <= mem_addr_d;
        end
    end

`ifdef LOADER_PREFETCH_EN
    // Holding buffer and outstanding-prefetch tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            pend_q     <= pend_d;
        end
    end
`endif

    assign busy         = busy_q;
    assign done         = done_q;
    assign mem_read     = mem_read_q;
    assign mem_address  = mem_addr_q;
    // Low element of the shift register is always the element on offer.
    assign fifo_wr_data = line_q[DATA_WIDTH-1:0];

endmodule
